jtlb: RTL and testbench
=======================

JTLB -- requirements
Module: jtlb

Interface
REQ-001 Parameter TLB_NUM, default 32, entry count (power of two, 8..64); IW = log2(TLB_NUM).
REQ-002 Parameter ASID_W, default 8, ASID width (EntryHi[ASID_W-1:0]).
REQ-003 Parameter PAGEMASK_EN, default 1; when 0, the written mask is forced to 0 (4 KB pages only).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 inst_req_i / data_req_i  in  1  lookup request per port.
REQ-007 inst_vaddr_i / data_vaddr_i  in  32  lookup virtual address.
REQ-008 cur_asid_i  in  ASID_W  current ASID for lookups and probe.
REQ-009 inst_rvalid_o, inst_found_o, inst_v_o  out  1  result valid, hit, entry V.
REQ-010 inst_paddr_o  out  32; inst_c_o  out  3.
REQ-011 data_rvalid_o, data_found_o, data_v_o, data_d_o  out  1; data_paddr_o  out  32; data_c_o  out  3.
REQ-012 inst_multi_o / data_multi_o  out  1  more than one entry matched.
REQ-013 cmd_valid_i  in  1; cmd_ready_o  out  1; cmd_op_i  in  3  (TLBP, TLBR, TLBWI, TLBWR, INVALL).
REQ-014 cp0_index_i, cp0_random_i, cp0_pagemask_i, cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i  in  32 each.
REQ-015 rsp_valid_o  out  1; rsp_index_o, rsp_pagemask_o, rsp_entryhi_o, rsp_entrylo0_o, rsp_entrylo1_o  out  32 each.

Function
REQ-016 Each entry SHALL hold: valid, mask[11:0], vpn2[18:0], g, asid, pfn0/1[19:0], c0/1, d0/1, v0/1.
REQ-017 An entry matches when valid && (vaddr[31:13] & ~{7'b0,mask}) == vpn2 && (g || asid == cur_asid_i).
REQ-018 The even/odd select bit SHALL be vaddr[12 + popcount(mask)]; paddr[31:12] = (pfn & ~{8'b0,mask}) | (vaddr[31:12] & {8'b0,mask}); paddr[11:0] = vaddr[11:0].
REQ-019 The lookup result SHALL appear exactly one cycle after the request, with rvalid high for that cycle only, computed from array contents in that result cycle.
REQ-020 On a multi-match, the lowest matching index SHALL supply the result and multi_o SHALL pulse with rvalid.
REQ-021 On a miss: found=0, paddr=0, c=0, v=0, d=0.
REQ-022 A command SHALL be accepted on cmd_valid_i && cmd_ready_o; cp0 inputs are sampled on that edge.
REQ-023 TLBP SHALL set rsp_index_o = {miss, 31-IW zeros, lowest matching index}, using cp0_entryhi_i[31:13] and cur_asid_i.
REQ-024 TLBR SHALL return the entry at cp0_index_i[IW-1:0] as follows:
- EntryHi = {vpn2, 5'b0, asid} (zero-padded);
- EntryLo = {6'b0, pfn, c, d, v, g};
- PageMask = {7'b0, mask, 13'b0}.
REQ-025 TLBWI / TLBWR SHALL write at cp0_index_i / cp0_random_i[IW-1:0] on the accept edge, as follows:
- set valid; g = lo0[0] & lo1[0];
- vpn2 = EntryHi[31:13] & ~mask; mask = PageMask[24:13].
REQ-026 Every non-INVALL command SHALL pulse rsp_valid_o exactly one cycle after accept; cmd_ready_o SHALL stay high in IDLE.
REQ-027 FSM states IDLE and FLUSH; INVALL accepted in IDLE SHALL enter FLUSH.
REQ-028 In FLUSH, a counter SHALL clear valid of entry k in cycle k (0..TLB_NUM-1), with cmd_ready_o=0.
REQ-029 In the last FLUSH cycle the FSM SHALL return to IDLE and rsp_valid_o SHALL pulse.
REQ-030 In FLUSH, lookups SHALL still return rvalid but with found=0.
REQ-031 rsp_* data outputs SHALL hold their last value until the next response.

Reset
REQ-032 rst SHALL immediately clear:
- all valid bits, the FSM (to IDLE) and the flush counter;
- all rvalid/found/multi/rsp_valid outputs and all paddr/rsp data outputs (to 0).
REQ-033 cmd_ready_o SHALL be 1 while in reset and after reset; reset mid-FLUSH SHALL abort the flush, leaving all entries invalid.

Structure
REQ-034 Op encodings (TLBP=0, TLBR=1, TLBWI=2, TLBWR=3, INVALL=4) and the TLB_NUM default SHALL live in the shared MMU constants package.
REQ-035 A sub-module jtlb_lookup (match, priority select, paddr merge, multi detect) SHALL be instantiated once per lookup port.

Verification
REQ-036 Write at idx 5: EntryHi=0x00402000, PageMask=0, lo0 = pfn 0x12345 V=1 C=3, lo1 = pfn 0x54321 V=1 D=1, G=1 -> data lookup of 0x00403ABC gives paddr 0x54321ABC, d=1, found=1 next cycle.
REQ-037 Write 16 KB entry (PageMask=0x00006000, EntryHi=0x10000000) -> lookup of 0x10005123 selects pfn1 (bit 14 = 1) and paddr[13:0] = 0x1123.
REQ-038 Same VPN in entries 3 and 9 -> result from entry 3, multi_o=1; TLBP returns 0x00000003.
REQ-039 INVALL with TLB_NUM=32 -> cmd_ready_o low for 32 cycles, rsp_valid_o pulses once, then every lookup misses and TLBP returns bit31=1.
REQ-040 Assert rst during FLUSH cycle 10 -> IDLE, cmd_ready_o=1, all lookups miss, no rsp_valid_o pulse.

Source files
------------

// File: rtl/jtlb_pkg.sv
// =============================================================================
// Module      : jtlb_pkg
// Description : Shared MMU constants, TLB entry layout and match helpers.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package jtlb_pkg;

    localparam int TLB_NUM_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_TLBP   = 3'd0,
        OP_TLBR   = 3'd1,
        OP_TLBWI  = 3'd2,
        OP_TLBWR  = 3'd3,
        OP_INVALL = 3'd4
    } tlb_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tlb_state_e;

    // Valid and ASID live outside the struct: valid needs async reset, ASID is parameterised.
    typedef struct packed {
        logic [11:0] mask;
        logic [18:0] vpn2;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    function automatic logic entry_match(input logic valid, input tlb_entry_t e,
                                         input logic [18:0] vpn, input logic asid_eq);
        return valid && ((vpn & ~{7'b0, e.mask}) == e.vpn2) && (e.g || asid_eq);
    endfunction

    function automatic logic [3:0] popcount12(input logic [11:0] m);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cnt = cnt + {3'b0, m[i]};
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtlb_lookup.sv
// =============================================================================
// Module      : jtlb_lookup
// Description : Combinational TLB search: match, lowest-index select, paddr merge.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module jtlb_lookup
    import jtlb_pkg::*;
#(
    parameter int TLB_NUM = TLB_NUM_DEFAULT,
    parameter int ASID_W  = 8
) (
    input  logic               en_i,
    input  logic [31:0]        vaddr_i,
    input  logic [ASID_W-1:0]  asid_i,
    input  logic [TLB_NUM-1:0] valid_i,
    input  tlb_entry_t         entries_i [TLB_NUM],
    input  logic [ASID_W-1:0]  asids_i   [TLB_NUM],
    output logic               found_o,
    output logic               multi_o,
    output logic [31:0]        paddr_o,
    output logic [2:0]         c_o,
    output logic               d_o,
    output logic               v_o
);

    localparam int IW = $clog2(TLB_NUM);

    logic          w_hit;
    logic          w_multi;
    logic [IW-1:0] w_sel;
    tlb_entry_t    w_e;
    logic [31:0]   w_shifted;
    logic          w_odd;
    logic [19:0]   w_pfn;
    logic [19:0]   w_ppn;
    logic          w_ok;

    always_comb begin
        w_hit   = 1'b0;
        w_multi = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            if (entry_match(valid_i[i], entries_i[i], vaddr_i[31:13], asids_i[i] == asid_i)) begin
                if (w_hit) begin
                    w_multi = 1'b1;
                end else begin
                    w_hit = 1'b1;
                    w_sel = IW'(i);
                end
            end
        end
    end

    // Even/odd page select bit moves up with the page size.
    assign w_e       = entries_i[w_sel];
    assign w_shifted = vaddr_i >> (32'd12 + 32'(popcount12(w_e.mask)));
    assign w_odd     = w_shifted[0];
    assign w_pfn     = w_odd ? w_e.pfn1 : w_e.pfn0;
    assign w_ppn     = (w_pfn & ~{8'b0, w_e.mask}) | (vaddr_i[31:12] & {8'b0, w_e.mask});
    assign w_ok      = en_i & w_hit;

    assign found_o = w_ok;
    assign multi_o = en_i & w_multi;
    assign paddr_o = w_ok ? {w_ppn, vaddr_i[11:0]} : 32'd0;
    assign c_o     = w_ok ? (w_odd ? w_e.c1 : w_e.c0) : 3'd0;
    assign d_o     = w_ok & (w_odd ? w_e.d1 : w_e.d0);
    assign v_o     = w_ok & (w_odd ? w_e.v1 : w_e.v0);

endmodule

`default_nettype wire

// File: rtl/jtlb.sv
// =============================================================================
// Module      : jtlb
// Description : Joint TLB with two lookup ports, CP0 command port and flush FSM.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module jtlb
    import jtlb_pkg::*;
#(
    parameter int TLB_NUM     = TLB_NUM_DEFAULT,
    parameter int ASID_W      = 8,
    parameter int PAGEMASK_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [31:0]       inst_vaddr_i,
    input  logic              data_req_i,
    input  logic [31:0]       data_vaddr_i,
    input  logic [ASID_W-1:0] cur_asid_i,
    output logic              inst_rvalid_o,
    output logic              inst_found_o,
    output logic              inst_v_o,
    output logic [31:0]       inst_paddr_o,
    output logic [2:0]        inst_c_o,
    output logic              inst_multi_o,
    output logic              data_rvalid_o,
    output logic              data_found_o,
    output logic              data_v_o,
    output logic              data_d_o,
    output logic [31:0]       data_paddr_o,
    output logic [2:0]        data_c_o,
    output logic              data_multi_o,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [31:0]       cp0_index_i,
    input  logic [31:0]       cp0_random_i,
    input  logic [31:0]       cp0_pagemask_i,
    input  logic [31:0]       cp0_entryhi_i,
    input  logic [31:0]       cp0_entrylo0_i,
    input  logic [31:0]       cp0_entrylo1_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_index_o,
    output logic [31:0]       rsp_pagemask_o,
    output logic [31:0]       rsp_entryhi_o,
    output logic [31:0]       rsp_entrylo0_o,
    output logic [31:0]       rsp_entrylo1_o
);

    localparam int IW = $clog2(TLB_NUM);

    tlb_state_e        state_q,  state_d;
    logic [IW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [TLB_NUM-1:0] valid_q, valid_d;
    tlb_entry_t        ent_q  [TLB_NUM];
    tlb_entry_t        ent_d  [TLB_NUM];
    logic [ASID_W-1:0] asid_q [TLB_NUM];
    logic [ASID_W-1:0] asid_d [TLB_NUM];
    logic              inst_req_q, data_req_q;
    logic [31:0]       inst_vaddr_q, data_vaddr_q;
    logic [ASID_W-1:0] inst_asid_q, data_asid_q;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_index_q, rsp_index_d, rsp_pagemask_q, rsp_pagemask_d;
    logic [31:0]       rsp_entryhi_q, rsp_entryhi_d, rsp_lo0_q, rsp_lo0_d, rsp_lo1_q, rsp_lo1_d;

    logic              w_accept;
    logic              w_flush_last;
    logic              w_probe_hit;
    logic [IW-1:0]     w_probe_idx;
    logic [IW-1:0]     w_rd_idx;
    logic [IW-1:0]     w_wr_idx;
    tlb_entry_t        w_rd;
    tlb_entry_t        w_new;
    logic              w_unused;

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign w_accept     = cmd_valid_i && cmd_ready_o;
    assign w_flush_last = (state_q == ST_FLUSH) && (flush_cnt_q == IW'(TLB_NUM - 1));
    assign w_rd_idx     = cp0_index_i[IW-1:0];
    assign w_wr_idx     = (cmd_op_i == OP_TLBWR) ? cp0_random_i[IW-1:0] : cp0_index_i[IW-1:0];
    assign w_rd         = ent_q[w_rd_idx];

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_probe_hit = 1'b0;
        w_probe_idx = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (entry_match(valid_q[i], ent_q[i], cp0_entryhi_i[31:13], asid_q[i] == cur_asid_i)) begin
                w_probe_hit = 1'b1;
                w_probe_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_new.mask = (PAGEMASK_EN != 0) ? cp0_pagemask_i[24:13] : 12'd0;
        w_new.vpn2 = cp0_entryhi_i[31:13] & ~{7'b0, w_new.mask};
        w_new.g    = cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
        w_new.pfn0 = cp0_entrylo0_i[25:6];
        w_new.pfn1 = cp0_entrylo1_i[25:6];
        w_new.c0   = cp0_entrylo0_i[5:3];
        w_new.c1   = cp0_entrylo1_i[5:3];
        w_new.d0   = cp0_entrylo0_i[2];
        w_new.d1   = cp0_entrylo1_i[2];
        w_new.v0   = cp0_entrylo0_i[1];
        w_new.v1   = cp0_entrylo1_i[1];
    end

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        valid_d        = valid_q;
        ent_d          = ent_q;
        asid_d         = asid_q;
        rsp_valid_d    = 1'b0;
        rsp_index_d    = rsp_index_q;
        rsp_pagemask_d = rsp_pagemask_q;
        rsp_entryhi_d  = rsp_entryhi_q;
        rsp_lo0_d      = rsp_lo0_q;
        rsp_lo1_d      = rsp_lo1_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    rsp_valid_d = (cmd_op_i != OP_INVALL);
                    case (cmd_op_i)
                        OP_TLBP: begin
                            rsp_index_d = {~w_probe_hit, {(31 - IW){1'b0}}, w_probe_idx};
                        end
                        OP_TLBR: begin
                            rsp_entryhi_d  = {w_rd.vpn2, 13'b0} | {{(32 - ASID_W){1'b0}}, asid_q[w_rd_idx]};
                            rsp_lo0_d      = {6'b0, w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g};
                            rsp_lo1_d      = {6'b0, w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g};
                            rsp_pagemask_d = {7'b0, w_rd.mask, 13'b0};
                        end
                        OP_TLBWI, OP_TLBWR: begin
                            valid_d[w_wr_idx] = 1'b1;
                            ent_d[w_wr_idx]   = w_new;
                            asid_d[w_wr_idx]  = cp0_entryhi_i[ASID_W-1:0];
                        end
                        OP_INVALL: begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                valid_d[flush_cnt_q] = 1'b0;
                flush_cnt_d          = flush_cnt_q + 1'b1;
                if (w_flush_last) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            valid_q        <= '0;
            inst_req_q     <= 1'b0;
            data_req_q     <= 1'b0;
            inst_vaddr_q   <= 32'd0;
            data_vaddr_q   <= 32'd0;
            inst_asid_q    <= '0;
            data_asid_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_index_q    <= 32'd0;
            rsp_pagemask_q <= 32'd0;
            rsp_entryhi_q  <= 32'd0;
            rsp_lo0_q      <= 32'd0;
            rsp_lo1_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            valid_q        <= valid_d;
            inst_req_q     <= inst_req_i;
            data_req_q     <= data_req_i;
            inst_vaddr_q   <= inst_vaddr_i;
            data_vaddr_q   <= data_vaddr_i;
            inst_asid_q    <= cur_asid_i;
            data_asid_q    <= cur_asid_i;
            rsp_valid_q    <= rsp_valid_d;
            rsp_index_q    <= rsp_index_d;
            rsp_pagemask_q <= rsp_pagemask_d;
            rsp_entryhi_q  <= rsp_entryhi_d;
            rsp_lo0_q      <= rsp_lo0_d;
            rsp_lo1_q      <= rsp_lo1_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q  <= ent_d;
        asid_q <= asid_d;
    end

    assign rsp_valid_o    = rsp_valid_q | w_flush_last;
    assign rsp_index_o    = rsp_index_q;
    assign rsp_pagemask_o = rsp_pagemask_q;
    assign rsp_entryhi_o  = rsp_entryhi_q;
    assign rsp_entrylo0_o = rsp_lo0_q;
    assign rsp_entrylo1_o = rsp_lo1_q;
    assign inst_rvalid_o  = inst_req_q;
    assign data_rvalid_o  = data_req_q;

    jtlb_lookup #(.TLB_NUM(TLB_NUM), .ASID_W(ASID_W)) u_inst_lookup (
        .en_i      (inst_req_q && (state_q == ST_IDLE)),
        .vaddr_i   (inst_vaddr_q),
        .asid_i    (inst_asid_q),
        .valid_i   (valid_q),
        .entries_i (ent_q),
        .asids_i   (asid_q),
        .found_o   (inst_found_o),
        .multi_o   (inst_multi_o),
        .paddr_o   (inst_paddr_o),
        .c_o       (inst_c_o),
        .d_o       (),
        .v_o       (inst_v_o)
    );

    jtlb_lookup #(.TLB_NUM(TLB_NUM), .ASID_W(ASID_W)) u_data_lookup (
        .en_i      (data_req_q && (state_q == ST_IDLE)),
        .vaddr_i   (data_vaddr_q),
        .asid_i    (data_asid_q),
        .valid_i   (valid_q),
        .entries_i (ent_q),
        .asids_i   (asid_q),
        .found_o   (data_found_o),
        .multi_o   (data_multi_o),
        .paddr_o   (data_paddr_o),
        .c_o       (data_c_o),
        .d_o       (data_d_o),
        .v_o       (data_v_o)
    );

    assign w_unused = ^{cp0_index_i[31:IW], cp0_random_i[31:IW], cp0_pagemask_i[31:25],
                        cp0_pagemask_i[12:0], cp0_entryhi_i[12:ASID_W],
                        cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};

endmodule

`default_nettype wire

// File: tb/tb_jtlb.sv
// =============================================================================
// Module      : tb_jtlb
// Description : Self-checking bench for jtlb: vector table plus scoreboard queues.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jtlb;
    import jtlb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_i = 1'b0, data_req_i = 1'b0;
    logic [31:0] inst_vaddr_i = '0, data_vaddr_i = '0;
    logic [7:0]  cur_asid_i = '0;
    logic        inst_rvalid_o, inst_found_o, inst_v_o, inst_multi_o;
    logic [31:0] inst_paddr_o;
    logic [2:0]  inst_c_o;
    logic        data_rvalid_o, data_found_o, data_v_o, data_d_o, data_multi_o;
    logic [31:0] data_paddr_o;
    logic [2:0]  data_c_o;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [2:0]  cmd_op_i = '0;
    logic [31:0] cp0_index_i = '0, cp0_random_i = '0, cp0_pagemask_i = '0;
    logic [31:0] cp0_entryhi_i = '0, cp0_entrylo0_i = '0, cp0_entrylo1_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_index_o, rsp_pagemask_o, rsp_entryhi_o, rsp_entrylo0_o, rsp_entrylo1_o;

    always #5 clk = ~clk;

    jtlb #(.TLB_NUM(32), .ASID_W(8), .PAGEMASK_EN(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_vaddr_i(inst_vaddr_i),
        .data_req_i(data_req_i), .data_vaddr_i(data_vaddr_i),
        .cur_asid_i(cur_asid_i),
        .inst_rvalid_o(inst_rvalid_o), .inst_found_o(inst_found_o), .inst_v_o(inst_v_o),
        .inst_paddr_o(inst_paddr_o), .inst_c_o(inst_c_o), .inst_multi_o(inst_multi_o),
        .data_rvalid_o(data_rvalid_o), .data_found_o(data_found_o), .data_v_o(data_v_o),
        .data_d_o(data_d_o), .data_paddr_o(data_paddr_o), .data_c_o(data_c_o),
        .data_multi_o(data_multi_o),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i),
        .cp0_pagemask_i(cp0_pagemask_i), .cp0_entryhi_i(cp0_entryhi_i),
        .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i),
        .rsp_valid_o(rsp_valid_o), .rsp_index_o(rsp_index_o),
        .rsp_pagemask_o(rsp_pagemask_o), .rsp_entryhi_o(rsp_entryhi_o),
        .rsp_entrylo0_o(rsp_entrylo0_o), .rsp_entrylo1_o(rsp_entrylo1_o)
    );

    typedef struct {
        logic        port;   // 1 = data port
        logic [31:0] va;
        logic        found;
        logic        multi;
        logic [31:0] pa;
        logic [2:0]  c;
        logic        v;
        logic        d;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t iq[$];
    vec_t dq[$];
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic port, input logic [31:0] va, input logic found,
                                input logic multi, input logic [31:0] pa, input logic [2:0] c,
                                input logic v, input logic d);
        vec_t r;
        r.port = port; r.va = va; r.found = found; r.multi = multi;
        r.pa = pa; r.c = c; r.v = v; r.d = d;
        return r;
    endfunction

    always @(negedge clk) begin : mon_data
        vec_t e;
        if (data_rvalid_o) begin
            if (dq.size() == 0) chk("data_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                chk("data_paddr", data_paddr_o, e.pa);
                chk("data_flags{found,multi,c,v,d}",
                    {data_found_o, data_multi_o, data_c_o, data_v_o, data_d_o},
                    {e.found, e.multi, e.c, e.v, e.d});
            end
        end
    end

    always @(negedge clk) begin : mon_inst
        vec_t e;
        if (inst_rvalid_o) begin
            if (iq.size() == 0) chk("inst_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                chk("inst_paddr", inst_paddr_o, e.pa);
                chk("inst_flags{found,multi,c,v}",
                    {inst_found_o, inst_multi_o, inst_c_o, inst_v_o},
                    {e.found, e.multi, e.c, e.v});
            end
        end
    end

    task automatic lookup(input vec_t v);
        @(posedge clk); #1;
        if (v.port) begin data_req_i = 1'b1; data_vaddr_i = v.va; dq.push_back(v); end
        else        begin inst_req_i = 1'b1; inst_vaddr_i = v.va; iq.push_back(v); end
        @(posedge clk); #1;
        data_req_i = 1'b0;
        inst_req_i = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] idx, input logic [31:0] rnd,
                       input logic [31:0] pm, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_op_i = op; cp0_index_i = idx; cp0_random_i = rnd;
        cp0_pagemask_i = pm; cp0_entryhi_i = hi; cp0_entrylo0_i = lo0; cp0_entrylo1_i = lo1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk); chk("rsp_valid_pulse", {31'd0, rsp_valid_o}, 32'd1);
        @(negedge clk); chk("rsp_valid_single", {31'd0, rsp_valid_o}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] idx, input logic [31:0] hi, input logic [31:0] pm,
                      input logic [31:0] lo0, input logic [31:0] lo1);
        cmd(OP_TLBWI, idx, 32'd31, pm, hi, lo0, lo1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : main
        int lows;
        int pulses;

        vt[0] = mk(1'b1, 32'h00403ABC, 1, 0, 32'h54321ABC, 3'd0, 1, 1);
        vt[1] = mk(1'b0, 32'h00402123, 1, 0, 32'h12345123, 3'd3, 1, 0);
        vt[2] = mk(1'b1, 32'h10005123, 1, 0, 32'h22221123, 3'd5, 1, 0);
        vt[3] = mk(1'b0, 32'h10001000, 1, 0, 32'h11111000, 3'd2, 1, 0);
        vt[4] = mk(1'b1, 32'h20000456, 1, 1, 32'h00AAA456, 3'd1, 1, 0);
        vt[5] = mk(1'b0, 32'h20001456, 1, 1, 32'h00000456, 3'd0, 0, 0);
        vt[6] = mk(1'b1, 32'h7FFFF000, 0, 0, 32'h0, 3'd0, 0, 0);
        vt[7] = mk(1'b1, 32'h30000000, 0, 0, 32'h0, 3'd0, 0, 0);
        vt[8] = mk(1'b0, 32'h30000000, 0, 0, 32'h0, 3'd0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_rvalid", {30'd0, inst_rvalid_o, data_rvalid_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_data_paddr", data_paddr_o, 32'd0);
        chk("rst_rsp_entryhi", rsp_entryhi_o, 32'd0);
        rst = 1'b0;

        lookup(mk(1'b1, 32'h00403ABC, 0, 0, 32'h0, 3'd0, 0, 0));

        // Populate: 4 KB global, 16 KB, duplicate VPN at 3 and 9 (via TLBWR), private ASID 0x11
        wr(5,  32'h00402000, 32'h0,        32'h0048D15B, 32'h0150C847);
        wr(7,  32'h10000000, 32'h00006000, 32'h00444452, 32'h0088882A);
        wr(3,  32'h20000000, 32'h0,        32'h0002AA8A, 32'h0);
        cmd(OP_TLBWR, 32'd0, 32'd9, 32'h0, 32'h20000000, 32'h0002EEC2, 32'h0);
        wr(12, 32'h30000011, 32'h0,        32'h00033302, 32'h0);

        for (int i = 0; i < 9; i++) lookup(vt[i]);

        @(posedge clk); #1;
        cur_asid_i = 8'h11;
        lookup(mk(1'b1, 32'h30000000, 1, 0, 32'h00CCC000, 3'd0, 1, 0));
        @(negedge clk);
        cur_asid_i = 8'h00;

        cmd(OP_TLBP, 32'd0, 32'd0, 32'd0, 32'h20000000, 32'd0, 32'd0);
        chk("tlbp_multi_index", rsp_index_o, 32'h00000003);
        cmd(OP_TLBP, 32'd0, 32'd0, 32'd0, 32'h7FFFF000, 32'd0, 32'd0);
        chk("tlbp_miss_index", rsp_index_o, 32'h80000000);

        cmd(OP_TLBR, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("tlbr5_entryhi", rsp_entryhi_o, 32'h00402000);
        chk("tlbr5_lo0", rsp_entrylo0_o, 32'h0048D15B);
        chk("tlbr5_lo1", rsp_entrylo1_o, 32'h0150C847);
        chk("tlbr5_pagemask", rsp_pagemask_o, 32'h0);
        cmd(OP_TLBR, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("tlbr7_entryhi", rsp_entryhi_o, 32'h10000000);
        chk("tlbr7_lo0", rsp_entrylo0_o, 32'h00444452);
        chk("tlbr7_lo1", rsp_entrylo1_o, 32'h0088882A);
        chk("tlbr7_pagemask", rsp_pagemask_o, 32'h00006000);
        cmd(OP_TLBR, 32'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("tlbr12_entryhi_asid", rsp_entryhi_o, 32'h30000011);
        chk("tlbr_hold_index", rsp_index_o, 32'h80000000);

        // Full flush, with a lookup landing in the first flush cycles (entry 5 still valid)
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_op_i = OP_INVALL;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        data_req_i = 1'b1; data_vaddr_i = 32'h00403ABC;
        dq.push_back(mk(1'b1, 32'h00403ABC, 0, 0, 32'h0, 3'd0, 0, 0));
        lows = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!cmd_ready_o) lows++;
            if (rsp_valid_o) pulses++;
            @(posedge clk); #1;
            data_req_i = 1'b0;
        end
        chk("flush_ready_low_cycles", lows, 32'd32);
        chk("flush_rsp_pulses", pulses, 32'd1);
        for (int i = 0; i < 6; i++) lookup(mk(vt[i].port, vt[i].va, 0, 0, 32'h0, 3'd0, 0, 0));
        cmd(OP_TLBP, 32'd0, 32'd0, 32'd0, 32'h00402000, 32'd0, 32'd0);
        chk("tlbp_after_flush", rsp_index_o, 32'h80000000);

        // Reset in flush cycle 10: entry 20 would have survived until cycle 20
        wr(5,  32'h00402000, 32'h0, 32'h0048D15B, 32'h0150C847);
        wr(20, 32'h40000000, 32'h0, 32'h00037743, 32'h00000001);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_op_i = OP_INVALL;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midflush_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("midflush_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("midflush_rst_rsp_index", rsp_index_o, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_o) pulses++;
            if (i == 2) rst = 1'b0;
        end
        chk("midflush_no_rsp_pulse", pulses, 32'd0);
        lookup(mk(1'b0, 32'h40000000, 0, 0, 32'h0, 3'd0, 0, 0));
        lookup(mk(1'b1, 32'h00403ABC, 0, 0, 32'h0, 3'd0, 0, 0));
        cmd(OP_TLBP, 32'd0, 32'd0, 32'd0, 32'h40000000, 32'd0, 32'd0);
        chk("tlbp_after_rst", rsp_index_o, 32'h80000000);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", iq.size() + dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
